// File: rtl/pattern_detector_pkg.sv
// rtl/pattern_detector_pkg.sv - shared constants and helpers for the pattern detector
package pattern_detector_pkg;

  localparam int DEF_SYM_W   = 3;
  localparam int DEF_SEQ_LEN = 8;

  // Slot 0 (lowest bits) is the first symbol expected: 001,101,110,000,110,110,011,101
  localparam logic [DEF_SEQ_LEN*DEF_SYM_W-1:0] DEFAULT_PATTERN =
    {3'b101, 3'b011, 3'b110, 3'b110, 3'b000, 3'b110, 3'b101, 3'b001};

  // Widest vector / symbol / counter the helpers handle
  localparam int VEC_MAX = 256;
  localparam int SYM_MAX = 32;
  localparam int CNT_MAX = 32;

  // Returns slot idx of a packed slot vector, zero-extended to SYM_MAX bits
  function automatic logic [SYM_MAX-1:0] slot_extract(input logic [VEC_MAX-1:0] vec,
                                                      input int idx, input int sym_w);
    logic [VEC_MAX-1:0] shifted;
    logic [SYM_MAX-1:0] mask;
    shifted = vec >> (idx * sym_w);
    mask    = (SYM_MAX'(1) << sym_w) - SYM_MAX'(1);
    return shifted[SYM_MAX-1:0] & mask;
  endfunction

  // Increments v, holding at the all-ones value of a w-bit counter
  function automatic logic [CNT_MAX-1:0] sat_inc(input logic [CNT_MAX-1:0] v, input int w);
    logic [CNT_MAX-1:0] top;
    top = (w >= CNT_MAX) ? '1 : ((CNT_MAX'(1) << w) - CNT_MAX'(1));
    return (v >= top) ? v : v + CNT_MAX'(1);
  endfunction

endpackage

// File: rtl/symbol_window.sv
// rtl/symbol_window.sv - sliding symbol window with saturating fill counter
module symbol_window
  import pattern_detector_pkg::*;
#(
  parameter int SYM_W   = DEF_SYM_W,
  parameter int SEQ_LEN = DEF_SEQ_LEN
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic                     restart,
  input  logic [SYM_W-1:0]         data_in,
  output logic [SEQ_LEN*SYM_W-1:0] window,
  output logic                     full
);

  localparam int W      = SEQ_LEN * SYM_W;
  localparam int FILL_W = $clog2(SEQ_LEN + 1);

  logic [W-1:0]      win_q;
  logic [FILL_W-1:0] fill_q;
  logic [FILL_W-1:0] fill_nx;

  // Look-ahead outputs: the window and fullness as they will be after this edge,
  // so the comparator can register its result in the same cycle the symbol lands.
  // restart is deliberately excluded here to keep the match/restart path loop-free.
  always_comb begin
    window  = win_q;
    fill_nx = fill_q;
    if (enable) begin
      window = {data_in, win_q[W-1:SYM_W]};
      if (fill_q != FILL_W'(SEQ_LEN)) fill_nx = fill_q + FILL_W'(1);
    end
    full = (fill_nx == FILL_W'(SEQ_LEN));
  end

  // Commit the shifted window; restart empties the fill count but keeps contents
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      win_q  <= '0;
      fill_q <= '0;
    end else begin
      win_q  <= window;
      fill_q <= restart ? '0 : fill_nx;
    end
  end

endmodule

// File: rtl/pattern_detector.sv
// rtl/pattern_detector.sv - run-time loadable sliding-window sequence detector
module pattern_detector
  import pattern_detector_pkg::*;
#(
  parameter int SYM_W   = DEF_SYM_W,
  parameter int SEQ_LEN = DEF_SEQ_LEN,
  parameter int CNT_W   = 8,
  parameter logic [SEQ_LEN*SYM_W-1:0] PATTERN = DEFAULT_PATTERN
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic [SYM_W-1:0]         data_in,
  input  logic                     overlap_en,
  input  logic                     pattern_load,
  input  logic [SEQ_LEN*SYM_W-1:0] pattern_in,
  input  logic                     count_clr,
  output logic                     match,
  output logic [CNT_W-1:0]         match_count
);

  // Helpers cover SEQ_LEN*SYM_W up to VEC_MAX, SYM_W up to SYM_MAX, CNT_W up to CNT_MAX

  logic [SEQ_LEN*SYM_W-1:0] pattern_q;
  logic [SEQ_LEN*SYM_W-1:0] window;
  logic                     full;
  logic                     accept;
  logic                     restart;
  logic                     match_next;
  logic [SEQ_LEN-1:0]       slot_eq;
  logic [CNT_MAX-1:0]       cnt_inc;

  // A load owns the cycle, so the symbol presented alongside it is dropped
  assign accept = enable & ~pattern_load;

  symbol_window #(
    .SYM_W   (SYM_W),
    .SEQ_LEN (SEQ_LEN)
  ) u_window (
    .clk     (clk),
    .reset   (reset),
    .enable  (accept),
    .restart (restart),
    .data_in (data_in),
    .window  (window),
    .full    (full)
  );

  // Slot-by-slot comparison of the post-shift window with the pattern
  for (genvar i = 0; i < SEQ_LEN; i++) begin : g_cmp
    assign slot_eq[i] = (slot_extract(VEC_MAX'(window), i, SYM_W) ==
                         slot_extract(VEC_MAX'(pattern_q), i, SYM_W));
  end

  assign match_next = accept & full & (&slot_eq);

  // Non-overlapping mode and pattern loads both demand a fresh full sequence
  assign restart = pattern_load | (match_next & ~overlap_en);

  assign cnt_inc = sat_inc(CNT_MAX'(match_count), CNT_W);

  // Pattern register, reloadable at run time
  always_ff @(posedge clk or posedge reset) begin
    if (reset)             pattern_q <= PATTERN;
    else if (pattern_load) pattern_q <= pattern_in;
  end

  // Registered match pulse and saturating detection counter; clear beats increment
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      match       <= 1'b0;
      match_count <= '0;
    end else begin
      match <= match_next;
      if (count_clr)       match_count <= '0;
      else if (match_next) match_count <= CNT_W'(cnt_inc);
    end
  end

endmodule

// File: tb/tb_pattern_detector.sv
// tb/tb_pattern_detector.sv - self-checking bench for pattern_detector
module tb_pattern_detector;

  localparam int SYM_W   = 3;
  localparam int SEQ_LEN = 8;
  localparam int CNT_W   = 2;
  localparam int PW      = SEQ_LEN * SYM_W;
  localparam int CNT_TOP = (1 << CNT_W) - 1;
  localparam logic [PW-1:0] DEF_PAT =
    {3'b101, 3'b011, 3'b110, 3'b110, 3'b000, 3'b110, 3'b101, 3'b001};
  localparam logic [PW-1:0] ALL7 = {8{3'b111}};
  localparam logic [PW-1:0] RAMP =
    {3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0};

  logic             clk = 1'b0;
  logic             reset;
  logic             enable;
  logic [SYM_W-1:0] data_in;
  logic             overlap_en;
  logic             pattern_load;
  logic [PW-1:0]    pattern_in;
  logic             count_clr;
  logic             match;
  logic [CNT_W-1:0] match_count;

  pattern_detector #(
    .SYM_W   (SYM_W),
    .SEQ_LEN (SEQ_LEN),
    .CNT_W   (CNT_W),
    .PATTERN (DEF_PAT)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .data_in      (data_in),
    .overlap_en   (overlap_en),
    .pattern_load (pattern_load),
    .pattern_in   (pattern_in),
    .count_clr    (count_clr),
    .match        (match),
    .match_count  (match_count)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  bit cmp_on = 1'b0;

  // Reference model: symbols accepted since the last restart, and the pattern
  int q[$];
  int pat[SEQ_LEN];
  bit nxt_match = 1'b0;
  int nxt_count = 0;
  bit exp_match;
  int exp_count;
  int ds[SEQ_LEN] = '{1, 5, 6, 0, 6, 6, 3, 5};

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_pat(input logic [PW-1:0] v);
    for (int i = 0; i < SEQ_LEN; i++) pat[i] = int'(v[i*SYM_W +: SYM_W]);
  endtask

  // Expected outcome of the coming clock edge, from the current inputs
  task automatic model_step();
    bit hit;
    hit = 1'b0;
    if (pattern_load) begin
      set_pat(pattern_in);
      q.delete();
    end else if (enable) begin
      q.push_back(int'(data_in));
      if (q.size() > SEQ_LEN) void'(q.pop_front());
      if (q.size() == SEQ_LEN) begin
        hit = 1'b1;
        for (int i = 0; i < SEQ_LEN; i++) if (q[i] != pat[i]) hit = 1'b0;
      end
      if (hit && !overlap_en) q.delete();
    end
    nxt_match = hit;
    if (count_clr)                    nxt_count = 0;
    else if (hit && exp_count < CNT_TOP) nxt_count = exp_count + 1;
    else                              nxt_count = exp_count;
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      exp_match <= 1'b0;
      exp_count <= 0;
    end else begin
      exp_match <= nxt_match;
      exp_count <= nxt_count;
    end
  end

  always @(negedge clk) begin
    if (cmp_on) begin
      check("cyc_match", int'(match), int'(exp_match));
      check("cyc_count", int'(match_count), exp_count);
    end
  end

  task automatic cyc(input logic en, input logic [SYM_W-1:0] d, input logic ld = 1'b0,
                     input logic [PW-1:0] pin = '0, input logic clr = 1'b0);
    enable = en; data_in = d; pattern_load = ld; pattern_in = pin; count_clr = clr;
    model_step();
    @(posedge clk);
    #1;
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear before any edge
  task automatic do_reset();
    reset = 1'b1;
    enable = 1'b0; pattern_load = 1'b0; count_clr = 1'b0;
    q.delete();
    set_pat(DEF_PAT);
    nxt_match = 1'b0;
    nxt_count = 0;
    #2;
    check("reset_match", int'(match), 0);
    check("reset_count", int'(match_count), 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    logic [PW-1:0] rp;
    int r;
    reset = 1'b0; enable = 1'b0; data_in = '0; overlap_en = 1'b0;
    pattern_load = 1'b0; pattern_in = '0; count_clr = 1'b0;
    #2;
    do_reset();
    cmp_on = 1'b1;

    // Default pattern, single match after the 8th symbol
    for (int i = 0; i < SEQ_LEN; i++) begin
      cyc(1'b1, SYM_W'(ds[i]));
      check("t1_match", int'(match), (i == 7) ? 1 : 0);
    end
    check("t1_count", int'(match_count), 1);
    cyc(1'b0, '0);
    check("t1_pulse_end", int'(match), 0);

    // Wrong final symbol, then reset in the middle of a sequence
    cyc(1'b0, '0, 1'b0, '0, 1'b1);
    check("t2_clr", int'(match_count), 0);
    for (int i = 0; i < SEQ_LEN; i++) begin
      cyc(1'b1, (i == 7) ? 3'b100 : SYM_W'(ds[i]));
      check("t2_nomatch", int'(match), 0);
    end
    cyc(1'b1, SYM_W'(ds[0]));
    cyc(1'b1, SYM_W'(ds[1]));
    do_reset();
    for (int i = 2; i < SEQ_LEN; i++) begin
      cyc(1'b1, SYM_W'(ds[i]));
      check("t2_after_reset", int'(match), 0);
    end
    check("t2_count", int'(match_count), 0);

    // All-111 pattern, overlapping then non-overlapping
    overlap_en = 1'b1;
    cyc(1'b0, '0, 1'b1, ALL7);
    cyc(1'b0, '0, 1'b0, '0, 1'b1);
    for (int i = 0; i < 9; i++) begin
      cyc(1'b1, 3'b111);
      check("t3_ovl_match", int'(match), (i >= 7) ? 1 : 0);
    end
    check("t3_ovl_count", int'(match_count), 2);
    overlap_en = 1'b0;
    cyc(1'b0, '0, 1'b1, ALL7, 1'b1);
    for (int i = 0; i < 16; i++) begin
      cyc(1'b1, 3'b111);
      check("t3_novl_match", int'(match), (i == 7 || i == 15) ? 1 : 0);
    end
    check("t3_novl_count", int'(match_count), 2);

    // Stall for 3 cycles between symbols 2 and 3 with data_in wiggling
    cyc(1'b0, '0, 1'b1, DEF_PAT, 1'b1);
    for (int i = 0; i < SEQ_LEN; i++) begin
      if (i == 2)
        for (int s = 0; s < 3; s++) begin
          cyc(1'b0, SYM_W'($urandom_range(0, 7)));
          check("t4_stall", int'(match), 0);
        end
      cyc(1'b1, SYM_W'(ds[i]));
      check("t4_match", int'(match), (i == 7) ? 1 : 0);
    end
    check("t4_count", int'(match_count), 1);

    // Saturation at 3 with five matches, then clear colliding with a match
    overlap_en = 1'b1;
    cyc(1'b0, '0, 1'b1, ALL7, 1'b1);
    for (int i = 0; i < 12; i++) cyc(1'b1, 3'b111);
    check("t5_sat", int'(match_count), 3);
    cyc(1'b1, 3'b111, 1'b0, '0, 1'b1);
    check("t5_clr_match", int'(match), 1);
    check("t5_clr_count", int'(match_count), 0);

    // Pattern load after 5 symbols discards progress and the same-cycle symbol
    overlap_en = 1'b0;
    cyc(1'b0, '0, 1'b1, DEF_PAT, 1'b1);
    for (int i = 0; i < 5; i++) cyc(1'b1, SYM_W'(ds[i]));
    cyc(1'b1, 3'b010, 1'b1, RAMP);
    check("t6_load", int'(match), 0);
    for (int i = 5; i < SEQ_LEN; i++) begin
      cyc(1'b1, SYM_W'(ds[i]));
      check("t6_old_tail", int'(match), 0);
    end
    for (int i = 0; i < SEQ_LEN; i++) begin
      cyc(1'b1, SYM_W'(i));
      check("t6_new_match", int'(match), (i == 7) ? 1 : 0);
    end
    check("t6_count", int'(match_count), 1);

    // Randomised traffic over a two-symbol alphabet so matches actually occur
    for (int n = 0; n < 3000; n++) begin
      r = $urandom_range(0, 199);
      overlap_en = ($urandom_range(0, 3) != 0);
      if (r < 3) begin
        for (int i = 0; i < SEQ_LEN; i++) rp[i*SYM_W +: SYM_W] = SYM_W'(6 + $urandom_range(0, 1));
        cyc($urandom_range(0, 1) == 1, 3'b110, 1'b1, rp);
      end else if (r == 3) begin
        do_reset();
      end else if (r < 8) begin
        cyc(1'b1, SYM_W'(6 + $urandom_range(0, 1)), 1'b0, '0, 1'b1);
      end else if (r < 30) begin
        cyc(1'b0, SYM_W'($urandom_range(0, 7)));
      end else if (r < 40) begin
        cyc(1'b1, SYM_W'($urandom_range(0, 7)));
      end else begin
        cyc(1'b1, SYM_W'(6 + $urandom_range(0, 1)));
      end
    end

    cmp_on = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pattern_detector.md
# pattern_detector

Parametrised successor to the fixed 3-bit/8-symbol sequence detector. It compares a sliding window of the last SEQ_LEN input symbols against a pattern that is loadable at run time, and pulses `match` when they are equal. It adds an enable/stall input, selectable overlapping or non-overlapping detection, and a saturating match counter. It sits between the symbol source and the control logic that consumes detection events.

## Interface
- SYM_W, 3: symbol width in bits, ≥1.
- SEQ_LEN, 8: pattern length in symbols, ≥2.
- CNT_W, 8: match counter width.
- PATTERN, {3'b101,3'b011,3'b110,3'b110,3'b000,3'b110,3'b101,3'b001}: reset pattern. Slot i is bits [i*SYM_W +: SYM_W]. Slot 0 is the first symbol expected.
- clk  in  1  single clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  qualifies data_in; when low the block holds its state.
- data_in  in  SYM_W  input symbol, sampled when enable=1.
- overlap_en  in  1  1 = overlapping detection; 0 = window restarts after each match.
- pattern_load  in  1  load pattern_in this cycle.
- pattern_in  in  SEQ_LEN*SYM_W  new pattern, same slot layout as PATTERN.
- count_clr  in  1  synchronous clear of match_count.
- match  out  1  registered one-cycle pulse per detection.
- match_count  out  CNT_W  number of detections, saturating.

## Operation
- State: pattern register (SEQ_LEN×SYM_W); window shift register (SEQ_LEN×SYM_W), where the newest symbol enters the top slot and the oldest sits in slot 0; fill counter 0..SEQ_LEN, saturating; match flop; match_count.
- Reset values: pattern=PATTERN, window=0, fill=0, match=0, match_count=0.
- Accepted symbol (enable=1, pattern_load=0): the window shifts, and fill increments up to SEQ_LEN.
- Detection: match_next=1 when the post-shift window equals the pattern and the post-shift fill equals SEQ_LEN. Because of the fill check, window contents left over from reset never produce a match.
- After a detection with overlap_en=0: fill is forced to 0, so the next match needs SEQ_LEN fresh symbols. With overlap_en=1: fill stays at SEQ_LEN, so every subsequent symbol can complete a match.
- enable=0: window, fill and pattern hold; match goes to 0.
- pattern_load=1: the pattern register takes pattern_in, fill goes to 0 and match goes to 0. pattern_load has priority over enable, so data_in that cycle is discarded.
- match_count increments on each cycle in which match_next=1, and saturates at 2^CNT_W−1.
- count_clr=1: match_count goes to 0. If count_clr and match_next occur in the same cycle, the clear wins and the count ends at 0. The match pulse is still produced.
- Changes to overlap_en take effect on the next accepted symbol.
- Reset asserted mid-sequence discards any partial progress. After release, a full SEQ_LEN-symbol sequence is required.

## Timing
- The final symbol of the pattern is sampled at edge k. match is high from edge k until edge k+1: one cycle of latency, registered, with no combinational path from inputs to outputs.
- match_count reflects that detection from edge k onward, i.e. in the same cycle as match.
- Back-to-back matches in overlapping mode give match high on consecutive cycles. There is no bubble.
- Asynchronous reset clears all outputs immediately. Release is synchronised by the integrator, not inside this block.

## Structure
- Package pattern_detector_pkg holds:
  - the default-pattern constant;
  - a slot-extract function (vector, index) returning a SYM_W slice;
  - the saturating-increment function.
- Sub-module symbol_window holds the window shift register plus fill counter. Its ports are enable, restart and data_in in; window and full out.
- The top level holds the pattern register, the comparator, the match flop and the counter.

## Test plan
- Default pattern fed 001,101,110,000,110,110,011,101 with enable=1 → match=1 for exactly one cycle after the 8th symbol; match_count=1.
- Same sequence but last symbol 100 → match stays 0 and match_count=0. Then reset mid-sequence after 001,101, followed by the remaining six symbols → no match.
- Load pattern all 3'b111 and feed nine consecutive 111:
  - overlap_en=1 → matches after the 8th and 9th symbols, match_count=2;
  - overlap_en=0 → one match after the 8th symbol, and the next match only after the 16th.
- Default sequence with enable=0 for 3 cycles between symbols 2 and 3 (data_in toggled while stalled) → single match after the 8th accepted symbol.
- CNT_W=2 with five matches → match_count saturates at 3. count_clr asserted in the same cycle as a match → match_count=0, and match still pulses.
- pattern_load asserted after 5 symbols of the default sequence → no match. The new pattern then matches only after a full SEQ_LEN-symbol sequence.
